// File: rtl/uart_reg_bridge_if.sv
// Bundle of the uart FIFO ports and the register bus seen by the bridge.
// The master modport is the bridge side; slave is the uart/register side.
interface uart_reg_bridge_if #(
    parameter int DataBytes = 4
);
    // uart RX FIFO
    logic                     i_rx_fifo_empty;
    logic                     o_rx_fifo_read;
    logic [7:0]               i_rx_fifo_rdata;
    // uart TX FIFO
    logic                     i_tx_fifo_full;
    logic                     o_tx_fifo_write;
    logic [7:0]               o_tx_fifo_wdata;
    // register bus
    logic                     o_reg_req;
    logic                     o_reg_we;
    logic [7:0]               o_reg_addr;
    logic [8*DataBytes-1:0]   o_reg_wdata;
    logic                     i_reg_ack;
    logic [8*DataBytes-1:0]   i_reg_rdata;

    modport master (
        input  i_rx_fifo_empty, i_rx_fifo_rdata, i_tx_fifo_full, i_reg_ack, i_reg_rdata,
        output o_rx_fifo_read, o_tx_fifo_write, o_tx_fifo_wdata,
               o_reg_req, o_reg_we, o_reg_addr, o_reg_wdata
    );

    modport slave (
        output i_rx_fifo_empty, i_rx_fifo_rdata, i_tx_fifo_full, i_reg_ack, i_reg_rdata,
        input  o_rx_fifo_read, o_tx_fifo_write, o_tx_fifo_wdata,
               o_reg_req, o_reg_we, o_reg_addr, o_reg_wdata
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: parses 'W'/'R' byte commands from the uart RX FIFO,
// performs one register access and pushes the response into the TX FIFO.
// Write frame: 'W' addr d0..dN-1 (LSB first) -> 'K'.
// Read frame : 'R' addr -> rdata bytes LSB first. Unknown command -> 'E'.
// An inter-byte timeout in ADDR/DATA discards a partial frame silently.
module uart_reg_bridge #(
    parameter int DataBytes   = 4,
    parameter int TimeoutBits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [TimeoutBits-1:0] c_timeout_cyc,
    uart_reg_bridge_if.master      bus,
    output logic                   o_busy
);

    localparam int DW = 8 * DataBytes;
    localparam int CW = $clog2(DataBytes + 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic                   is_write_q, is_write_d;
    logic [7:0]             addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          resp_q, resp_d;      // response shift register, low byte goes out first
    logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [TimeoutBits-1:0] tmo_cnt_q, tmo_cnt_d;

    logic                   rx_read;
    logic                   tx_write;
    logic                   reg_req;
    logic                   tmo_hit;
    logic [TimeoutBits-1:0] tmo_inc;
    logic [7:0]             rx_byte;

    assign rx_byte = bus.i_rx_fifo_rdata;

    // Next-state, datapath updates and handshake strobes
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        rx_read    = 1'b0;
        tx_write   = 1'b0;
        reg_req    = 1'b0;
        // A zero threshold disables the abort entirely
        tmo_hit    = (c_timeout_cyc != '0) && (tmo_cnt_q == c_timeout_cyc);
        // Saturate so a disabled timeout never wraps into a false match later
        tmo_inc    = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TimeoutBits'(1);

        unique case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = S_CMD;
            end

            S_CMD: begin
                if (!bus.i_rx_fifo_empty) begin
                    rx_read = 1'b1;
                    if (rx_byte == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else if (rx_byte == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        resp_d     = DW'(RSP_ERR);
                        byte_cnt_d = CW'(1);
                        state_d    = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                // Abort wins over a byte arriving the same cycle so nothing is popped
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (!bus.i_rx_fifo_empty) begin
                    rx_read   = 1'b1;
                    addr_d    = rx_byte;
                    tmo_cnt_d = '0;
                    state_d   = is_write_q ? S_DATA : S_REQ;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end

            S_DATA: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (!bus.i_rx_fifo_empty) begin
                    rx_read   = 1'b1;
                    tmo_cnt_d = '0;
                    for (int k = 0; k < DataBytes; k++) begin
                        if (byte_cnt_q == CW'(k)) begin
                            wdata_d[8*k +: 8] = rx_byte;
                        end
                    end
                    if (byte_cnt_q == CW'(DataBytes - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_REQ;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end

            S_REQ: begin
                reg_req = 1'b1;
                if (bus.i_reg_ack) begin
                    if (is_write_q) begin
                        resp_d     = DW'(RSP_OK);
                        byte_cnt_d = CW'(1);
                    end else begin
                        resp_d     = bus.i_reg_rdata;
                        byte_cnt_d = CW'(DataBytes);
                    end
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (!bus.i_tx_fifo_full) begin
                    tx_write   = 1'b1;
                    resp_d     = resp_q >> 8;
                    byte_cnt_d = byte_cnt_q - CW'(1);
                    if (byte_cnt_q == CW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset puts every output at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Strobes are combinational from state so they drop as soon as reset asserts
    assign bus.o_rx_fifo_read  = rx_read;
    assign bus.o_tx_fifo_write = tx_write;
    assign bus.o_tx_fifo_wdata = resp_q[7:0];
    assign bus.o_reg_req       = reg_req;
    assign bus.o_reg_we        = is_write_q;
    assign bus.o_reg_addr      = addr_q;
    assign bus.o_reg_wdata     = wdata_q;
    assign o_busy              = (state_q != S_IDLE);

endmodule
